operand_issue_ctrl: RTL and testbench



---
 rtl/operand_issue_ctrl_pkg.sv | 26 ++
 rtl/operand_issue_ctrl_reg_scoreboard.sv | 62 ++++++
 rtl/operand_issue_ctrl.sv | 106 ++++++++++
 tb/tb_operand_issue_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/operand_issue_ctrl_pkg.sv
// Shared decode constants and helpers for the stage-1 to stage-2 issue path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package operand_issue_ctrl_pkg;

    localparam int OPCODE_W        = 6;
    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 32;
    localparam int IMM_BIT_DEFAULT = 3;
    // Scoreboard counters are 3 bits wide, so writeback latency is limited to 1..7.
    localparam int SB_CNT_W        = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP = '0;

    // The all-zero opcode is the pipeline NOP.
    function automatic logic is_nop(input logic [OPCODE_W-1:0] op);
        return (op == OP_NOP);
    endfunction

    // Immediate-form instructions take operand B from the immediate field.
    function automatic logic is_imm(input logic [OPCODE_W-1:0] op,
                                    input logic [2:0]          bit_idx);
        return op[bit_idx];
    endfunction

endpackage

// File: rtl/operand_issue_ctrl_reg_scoreboard.sv
// Per-register pending-writeback scoreboard: 32 down-counters, two read ports, one load port.
// Latency: pending reads are combinational from the counters; a load is visible the next cycle.
// Backpressure: none; a load always wins over the decrement of the same entry.
module reg_scoreboard
    import operand_issue_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rd_sel_a_i,
    input  logic [REG_ADDR_W-1:0] rd_sel_b_i,
    output logic                  pend_a_o,
    output logic                  pend_b_o,
    input  logic                  ld_en_i,
    input  logic [REG_ADDR_W-1:0] ld_sel_i
);

    localparam logic [SB_CNT_W-1:0] LOAD_VAL = SB_CNT_W'(WB_LATENCY);

    logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend;

    // Next count per entry: a load restarts the count, otherwise count down to zero.
    // r0 is hardwired, so its entry is never loaded and stays at zero.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (ld_en_i && (ld_sel_i == REG_ADDR_W'(r)) && (r != 0)) begin
                cnt_d[r] = LOAD_VAL;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    // Counter state; synchronous reset clears every pending writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Pending flags; entry 0 is forced clear so reads of r0 never hazard.
    always_comb begin
        pend = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pend[r] = (cnt_q[r] != '0);
        end
    end

    assign pend_a_o = pend[rd_sel_a_i];
    assign pend_b_o = pend[rd_sel_b_i];

endmodule

// File: rtl/operand_issue_ctrl.sv
// Stage-1 to stage-2 issue controller: decode, RAW hazard stall, stage-2 control registers.
// Latency: one cycle from issue to S2_* outputs; a RAW dependent waits WB_LATENCY cycles.
// Backpressure: Stall holds stage 1 while a source register has a pending writeback.
module operand_issue_ctrl
    import operand_issue_ctrl_pkg::*;
#(
    parameter int WB_LATENCY  = 3,
    parameter int IMM_BIT     = IMM_BIT_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   S1_Valid,
    input  logic [OPCODE_W-1:0]    S1_OpCode,
    input  logic [REG_ADDR_W-1:0]  S1_ReadSelect1,
    input  logic [REG_ADDR_W-1:0]  S1_ReadSelect2,
    input  logic [REG_ADDR_W-1:0]  S1_WriteSelect,
    output logic                   Stall,
    output logic                   S2_Valid,
    output logic                   S2_DataSource,
    output logic [REG_ADDR_W-1:0]  S2_WriteSelect,
    output logic [STALL_CNT_W-1:0] StallCount
);

    logic s1_nop;
    logic s1_imm;
    logic s1_uses_b;
    logic s1_writes;
    logic pend_a;
    logic pend_b;
    logic hazard;
    logic issue;
    logic sb_ld_en;

    logic                   s2_valid_q, s2_valid_d;
    logic                   s2_dsrc_q,  s2_dsrc_d;
    logic [REG_ADDR_W-1:0]  s2_wsel_q,  s2_wsel_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Decode of the stage-1 instruction; immediate forms do not read register B.
    always_comb begin
        s1_nop    = is_nop(S1_OpCode);
        s1_imm    = is_imm(S1_OpCode, 3'(IMM_BIT));
        s1_uses_b = !s1_imm;
        s1_writes = !s1_nop && (S1_WriteSelect != '0);
    end

    reg_scoreboard #(
        .WB_LATENCY (WB_LATENCY)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .rd_sel_a_i (S1_ReadSelect1),
        .rd_sel_b_i (S1_ReadSelect2),
        .pend_a_o   (pend_a),
        .pend_b_o   (pend_b),
        .ld_en_i    (sb_ld_en),
        .ld_sel_i   (S1_WriteSelect)
    );

    // Hazard is judged against pre-issue scoreboard state, so rd==rs only stalls
    // when an older write to that register is still in flight.
    always_comb begin
        hazard   = S1_Valid && !s1_nop && (pend_a || (s1_uses_b && pend_b));
        issue    = S1_Valid && !hazard;
        sb_ld_en = issue && s1_writes;
        // Counters may still read nonzero during reset; never stall while resetting.
        Stall    = hazard && !reset;
    end

    // Stage-2 control next state: a stall or an empty stage 1 registers a bubble.
    always_comb begin
        s2_valid_d = issue && !s1_nop;
        s2_dsrc_d  = issue ? s1_imm : 1'b0;
        s2_wsel_d  = issue ? S1_WriteSelect : '0;
    end

    // Saturating statistics counter of stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stage-2 pipeline control and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_dsrc_q   <= 1'b0;
            s2_wsel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            s2_valid_q  <= s2_valid_d;
            s2_dsrc_q   <= s2_dsrc_d;
            s2_wsel_q   <= s2_wsel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign S2_Valid       = s2_valid_q;
    assign S2_DataSource  = s2_dsrc_q;
    assign S2_WriteSelect = s2_wsel_q;
    assign StallCount     = stall_cnt_q;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Directed bench for operand_issue_ctrl with WB_LATENCY=3, IMM_BIT=3.
// Each vector is one cycle: inputs driven after the rising edge, outputs checked on the falling edge.
// Expected S2_* and StallCount reflect the previous edge; Stall reflects this cycle's inputs.
module tb_operand_issue_ctrl;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_NOP  = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        S1_Valid;
    logic [5:0]  S1_OpCode;
    logic [4:0]  S1_ReadSelect1;
    logic [4:0]  S1_ReadSelect2;
    logic [4:0]  S1_WriteSelect;
    logic        Stall;
    logic        S2_Valid;
    logic        S2_DataSource;
    logic [4:0]  S2_WriteSelect;
    logic [15:0] StallCount;

    always #5 clk = ~clk;

    operand_issue_ctrl #(
        .WB_LATENCY  (3),
        .IMM_BIT     (3),
        .STALL_CNT_W (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .S1_Valid       (S1_Valid),
        .S1_OpCode      (S1_OpCode),
        .S1_ReadSelect1 (S1_ReadSelect1),
        .S1_ReadSelect2 (S1_ReadSelect2),
        .S1_WriteSelect (S1_WriteSelect),
        .Stall          (Stall),
        .S2_Valid       (S2_Valid),
        .S2_DataSource  (S2_DataSource),
        .S2_WriteSelect (S2_WriteSelect),
        .StallCount     (StallCount)
    );

    typedef struct {
        logic        vld;
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        e_stall;
        logic        e_s2v;
        logic        e_ds;
        logic [4:0]  e_ws;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic vld, input logic [5:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic e_stall,
                       input logic e_s2v, input logic e_ds, input logic [4:0] e_ws,
                       input logic [15:0] e_sc);
        vec_t v;
        v.vld = vld; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.e_stall = e_stall; v.e_s2v = e_s2v; v.e_ds = e_ds; v.e_ws = e_ws; v.e_sc = e_sc;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // One cycle: drive, check on the falling edge, advance past the next rising edge.
    task automatic step(input int idx, input logic rst, input vec_t v);
        reset          = rst;
        S1_Valid       = v.vld;
        S1_OpCode      = v.op;
        S1_ReadSelect1 = v.rs1;
        S1_ReadSelect2 = v.rs2;
        S1_WriteSelect = v.rd;
        @(negedge clk);
        chk("Stall",          idx, 16'(Stall),          16'(v.e_stall));
        chk("S2_Valid",       idx, 16'(S2_Valid),       16'(v.e_s2v));
        chk("S2_DataSource",  idx, 16'(S2_DataSource),  16'(v.e_ds));
        chk("S2_WriteSelect", idx, 16'(S2_WriteSelect), 16'(v.e_ws));
        chk("StallCount",     idx, StallCount,          v.e_sc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t hv;

        //   vld op       rs1 rs2 rd   stall s2v ds ws  sc
        add(1, OP_ADD,  2,  3,  1,   0,    0,  0, 0,  0);  // 0  r1=r2+r3
        add(1, OP_ADDI, 0,  0,  5,   0,    1,  0, 1,  0);  // 1  r5=r0+imm
        add(1, OP_ADD,  5,  2,  6,   1,    1,  1, 5,  0);  // 2  r6=r5+r2 stalls
        add(1, OP_ADD,  5,  2,  6,   1,    0,  0, 0,  1);  // 3
        add(1, OP_ADD,  5,  2,  6,   1,    0,  0, 0,  2);  // 4
        add(1, OP_ADD,  5,  2,  6,   0,    0,  0, 0,  3);  // 5  issues
        add(0, OP_NOP,  0,  0,  0,   0,    1,  0, 6,  3);  // 6  idle
        add(1, OP_ADDI, 0,  0,  5,   0,    0,  0, 0,  3);  // 7  r5 pending again
        add(1, OP_ADDI, 2,  5,  7,   0,    1,  1, 5,  3);  // 8  imm, rs2=r5 unused
        add(1, OP_ADD,  2,  5,  8,   1,    1,  1, 7,  3);  // 9  reg form stalls on r5
        add(1, OP_ADD,  2,  5,  8,   1,    0,  0, 0,  4);  // 10
        add(1, OP_ADD,  2,  5,  8,   0,    0,  0, 0,  5);  // 11
        add(1, OP_ADD,  2,  3,  0,   0,    1,  0, 8,  5);  // 12 write r0
        add(1, OP_ADD,  0,  0,  9,   0,    1,  0, 0,  5);  // 13 read r0
        add(1, OP_NOP,  9,  9, 10,   0,    1,  0, 9,  5);  // 14 NOP, r9 pending
        add(1, OP_ADD, 10,  2, 11,   0,    0,  0, 10, 5);  // 15 r10 not loaded
        add(1, OP_ADDI, 4,  0,  4,   0,    1,  0, 11, 5);  // 16 r4=r4+1
        add(1, OP_ADDI, 4,  0,  4,   1,    1,  1, 4,  5);  // 17 r4=r4+1 again
        add(1, OP_ADDI, 4,  0,  4,   1,    0,  0, 0,  6);  // 18
        add(1, OP_ADDI, 4,  0,  4,   1,    0,  0, 0,  7);  // 19
        add(1, OP_ADDI, 4,  0,  4,   0,    0,  0, 0,  8);  // 20 issues, reloads r4
        add(1, OP_ADD,  4,  2, 12,   1,    1,  1, 4,  8);  // 21 sees reload
        add(0, OP_NOP,  0,  0,  0,   0,    0,  0, 0,  9);  // 22 idle, counters run
        add(1, OP_ADD,  4,  2, 12,   1,    0,  0, 0,  9);  // 23
        add(1, OP_ADD,  4,  2, 12,   0,    0,  0, 0, 10);  // 24
        add(0, OP_NOP,  0,  0,  0,   0,    1,  0, 12, 10); // 25
        add(1, OP_ADD,  2,  3, 13,   0,    0,  0, 0, 10);  // 26 r13 write
        add(1, OP_ADD,  2,  3, 13,   0,    1,  0, 13, 10); // 27 r13 rewrite
        add(1, OP_ADD, 13,  2, 14,   1,    1,  0, 13, 10); // 28 full 3 stalls
        add(1, OP_ADD, 13,  2, 14,   1,    0,  0, 0, 11);  // 29
        add(1, OP_ADD, 13,  2, 14,   1,    0,  0, 0, 12);  // 30
        add(1, OP_ADD, 13,  2, 14,   0,    0,  0, 0, 13);  // 31
        add(0, OP_NOP,  0,  0,  0,   0,    1,  0, 14, 13); // 32

        // Reset for two cycles with stage 1 empty.
        reset = 1'b1; S1_Valid = 1'b0; S1_OpCode = OP_NOP;
        S1_ReadSelect1 = '0; S1_ReadSelect2 = '0; S1_WriteSelect = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_Stall",      -1, 16'(Stall),          16'd0);
        chk("rst_S2_Valid",   -1, 16'(S2_Valid),       16'd0);
        chk("rst_S2_DataSrc", -1, 16'(S2_DataSource),  16'd0);
        chk("rst_S2_WrSel",   -1, 16'(S2_WriteSelect), 16'd0);
        chk("rst_StallCount", -1, StallCount,          16'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            step(i, 1'b0, vt[i]);
        end

        // Reset asserted on the second stall cycle of a held dependent.
        hv = '{1, OP_ADD, 2, 3, 15, 0, 0, 0, 0, 13};
        step(100, 1'b0, hv);                               // r15 write issues
        hv = '{1, OP_ADD, 15, 2, 16, 1, 1, 0, 15, 13};
        step(101, 1'b0, hv);                               // first stall cycle
        hv = '{1, OP_ADD, 15, 2, 16, 0, 0, 0, 0, 14};
        step(102, 1'b1, hv);                               // reset: Stall suppressed
        hv = '{1, OP_ADD, 15, 2, 16, 0, 0, 0, 0, 0};
        step(103, 1'b0, hv);                               // held instr issues
        hv = '{1, OP_ADD, 16, 2, 17, 1, 1, 0, 16, 0};
        step(104, 1'b0, hv);                               // count restarts from 0
        hv = '{0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 1};
        step(105, 1'b0, hv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
